// File: rtl/dec_err_mon.sv
// Error monitor behind the 32-bit SEC-DED decoder: classifies results, keeps saturating
// error counters, captures the first error, raises IRQ and queues single-bit scrub writes.
module dec_err_mon #(
    parameter int AW = 16,
    parameter int CW = 16,
    parameter int QD = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          VLD,
    input  logic [AW-1:0] ADDR,
    input  logic [38:0]   OUT,
    input  logic [6:0]    SYN,
    input  logic          ERR,
    input  logic          SGL,
    input  logic          DBL,
    input  logic          CLR,
    input  logic          IRQ_EN,
    output logic [CW-1:0] SGL_CNT,
    output logic [CW-1:0] DBL_CNT,
    output logic          CAP_VLD,
    output logic          CAP_DBL,
    output logic [AW-1:0] CAP_ADDR,
    output logic [6:0]    CAP_SYN,
    output logic          CAP_OVF,
    output logic          WB_DROP,
    output logic          IRQ,
    output logic          WB_VLD,
    output logic [AW-1:0] WB_ADDR,
    output logic [38:0]   WB_DATA,
    input  logic          WB_RDY
);

    localparam int PW = (QD > 1) ? $clog2(QD) : 1;

    logic [CW-1:0] sgl_cnt_r;
    logic [CW-1:0] dbl_cnt_r;
    logic          cap_vld_r;
    logic          cap_dbl_r;
    logic [AW-1:0] cap_addr_r;
    logic [6:0]    cap_syn_r;
    logic          cap_ovf_r;
    logic          wb_drop_r;

    logic [AW-1:0] addr_mem_r [QD];
    logic [38:0]   data_mem_r [QD];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   fill_r;

    logic          evt_u_s;
    logic          evt_s_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == {CW{1'b1}}) begin
            r = v;
        end else begin
            r = v + CW'(1);
        end
        return r;
    endfunction

    // Event classification and queue handshake decode
    always_comb begin
        evt_u_s = 1'b0;
        evt_s_s = 1'b0;
        if (VLD) begin
            evt_u_s = DBL | (ERR & ~SGL);
            evt_s_s = SGL & ~DBL;
        end else begin
            evt_u_s = 1'b0;
            evt_s_s = 1'b0;
        end
        full_s  = (fill_r == (PW+1)'(QD));
        empty_s = (fill_r == (PW+1)'(0));
        pop_s   = ~empty_s & WB_RDY;
        // A same-cycle pop frees the slot, so a push into a full queue is still accepted
        push_s  = evt_s_s & (~full_s | pop_s);
        drop_s  = evt_s_s & full_s & ~pop_s;
    end

    // Saturating error counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgl_cnt_r <= {CW{1'b0}};
            dbl_cnt_r <= {CW{1'b0}};
        end else if (CLR) begin
            sgl_cnt_r <= {CW{1'b0}};
            dbl_cnt_r <= {CW{1'b0}};
        end else begin
            if (evt_s_s) sgl_cnt_r <= sat_inc(sgl_cnt_r);
            if (evt_u_s) dbl_cnt_r <= sat_inc(dbl_cnt_r);
        end
    end

    // First-error capture, overflow and drop sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_r  <= 1'b0;
            cap_dbl_r  <= 1'b0;
            cap_addr_r <= {AW{1'b0}};
            cap_syn_r  <= 7'd0;
            cap_ovf_r  <= 1'b0;
            wb_drop_r  <= 1'b0;
        end else if (CLR) begin
            cap_vld_r  <= 1'b0;
            cap_dbl_r  <= 1'b0;
            cap_addr_r <= {AW{1'b0}};
            cap_syn_r  <= 7'd0;
            cap_ovf_r  <= 1'b0;
            wb_drop_r  <= 1'b0;
        end else begin
            if ((evt_s_s | evt_u_s) && !cap_vld_r) begin
                cap_vld_r  <= 1'b1;
                cap_dbl_r  <= evt_u_s;
                cap_addr_r <= ADDR;
                cap_syn_r  <= SYN;
            end else if (evt_s_s | evt_u_s) begin
                cap_ovf_r  <= 1'b1;
            end
            if (drop_s) wb_drop_r <= 1'b1;
        end
    end

    // Scrub queue storage; CLR deliberately leaves pending write-backs intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QD; i++) begin
                addr_mem_r[i] <= {AW{1'b0}};
                data_mem_r[i] <= 39'd0;
            end
        end else if (push_s) begin
            addr_mem_r[wr_ptr_r] <= ADDR;
            data_mem_r[wr_ptr_r] <= OUT;
        end
    end

    // Scrub queue pointers and fill level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            fill_r   <= {(PW+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   fill_r <= fill_r + (PW+1)'(1);
                2'b01:   fill_r <= fill_r - (PW+1)'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    assign SGL_CNT  = sgl_cnt_r;
    assign DBL_CNT  = dbl_cnt_r;
    assign CAP_VLD  = cap_vld_r;
    assign CAP_DBL  = cap_dbl_r;
    assign CAP_ADDR = cap_addr_r;
    assign CAP_SYN  = cap_syn_r;
    assign CAP_OVF  = cap_ovf_r;
    assign WB_DROP  = wb_drop_r;
    assign IRQ      = IRQ_EN & (cap_vld_r | wb_drop_r);
    assign WB_VLD   = ~empty_s;
    assign WB_ADDR  = addr_mem_r[rd_ptr_r];
    assign WB_DATA  = data_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_dec_err_mon.sv
// Directed-vector bench for dec_err_mon (AW=16, CW=4, QD=2).
module tb_dec_err_mon;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        VLD, ERR, SGL, DBL, CLR, IRQ_EN, WB_RDY;
    logic [15:0] ADDR;
    logic [38:0] OUT;
    logic [6:0]  SYN;
    logic [3:0]  SGL_CNT, DBL_CNT;
    logic        CAP_VLD, CAP_DBL, CAP_OVF, WB_DROP, IRQ, WB_VLD;
    logic [15:0] CAP_ADDR, WB_ADDR;
    logic [6:0]  CAP_SYN;
    logic [38:0] WB_DATA;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dec_err_mon #(.AW(16), .CW(4), .QD(2)) dut (
        .clk(clk), .rst_n(rst_n), .VLD(VLD), .ADDR(ADDR), .OUT(OUT), .SYN(SYN),
        .ERR(ERR), .SGL(SGL), .DBL(DBL), .CLR(CLR), .IRQ_EN(IRQ_EN),
        .SGL_CNT(SGL_CNT), .DBL_CNT(DBL_CNT), .CAP_VLD(CAP_VLD), .CAP_DBL(CAP_DBL),
        .CAP_ADDR(CAP_ADDR), .CAP_SYN(CAP_SYN), .CAP_OVF(CAP_OVF), .WB_DROP(WB_DROP),
        .IRQ(IRQ), .WB_VLD(WB_VLD), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .WB_RDY(WB_RDY)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        VLD = 1'b0; ERR = 1'b0; SGL = 1'b0; DBL = 1'b0;
        ADDR = 16'h0000; OUT = 39'h0; SYN = 7'h00;
    endtask

    // Present one decoder result for one clock, then return inputs to idle
    task automatic ev(input logic e, input logic s, input logic d,
                      input logic [15:0] a, input logic [38:0] o, input logic [6:0] sy);
        VLD = 1'b1; ERR = e; SGL = s; DBL = d; ADDR = a; OUT = o; SYN = sy;
        step();
        idle_inputs();
    endtask

    task automatic clr_pulse();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        CLR = 1'b0; IRQ_EN = 1'b1; WB_RDY = 1'b0; rst_n = 1'b0;
        step(); step();
        checks++; if (SGL_CNT !== 4'd0) begin errors++; $display("FAIL rst_sgl_cnt got %0d want 0", SGL_CNT); end
        checks++; if (DBL_CNT !== 4'd0) begin errors++; $display("FAIL rst_dbl_cnt got %0d want 0", DBL_CNT); end
        checks++; if ({CAP_VLD, CAP_DBL, CAP_OVF, WB_DROP, IRQ, WB_VLD} !== 6'b0) begin errors++; $display("FAIL rst_flags got %b want 000000", {CAP_VLD, CAP_DBL, CAP_OVF, WB_DROP, IRQ, WB_VLD}); end
        checks++; if ({CAP_ADDR, CAP_SYN, WB_ADDR, WB_DATA} !== 78'h0) begin errors++; $display("FAIL rst_data got %h want 0", {CAP_ADDR, CAP_SYN, WB_ADDR, WB_DATA}); end
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        ev(1'b1, 1'b1, 1'b0, 16'h0012, 39'h0, 7'b0000011);
        checks++; if (SGL_CNT !== 4'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", SGL_CNT); end
        checks++; if (CAP_VLD !== 1'b1 || CAP_DBL !== 1'b0) begin errors++; $display("FAIL single_cap got vld=%b dbl=%b want 1 0", CAP_VLD, CAP_DBL); end
        checks++; if (CAP_SYN !== 7'b0000011 || CAP_ADDR !== 16'h0012) begin errors++; $display("FAIL single_cap_data got syn=%b addr=%h want 0000011 0012", CAP_SYN, CAP_ADDR); end
        checks++; if (WB_VLD !== 1'b1 || WB_ADDR !== 16'h0012) begin errors++; $display("FAIL single_wb got vld=%b addr=%h want 1 0012", WB_VLD, WB_ADDR); end
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL single_irq got %b want 1", IRQ); end
        IRQ_EN = 1'b0; #1;
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL single_irq_masked got %b want 0", IRQ); end
        IRQ_EN = 1'b1;
        WB_RDY = 1'b1; step(); WB_RDY = 1'b0;
        checks++; if (WB_VLD !== 1'b0) begin errors++; $display("FAIL single_pop got wb_vld=%b want 0", WB_VLD); end
        clr_pulse();
        checks++; if ({SGL_CNT, CAP_VLD, IRQ} !== 6'b0) begin errors++; $display("FAIL single_clr got %b want 000000", {SGL_CNT, CAP_VLD, IRQ}); end
    endtask

    task automatic test_dbl_then_sgl();
        ev(1'b1, 1'b0, 1'b1, 16'h0005, 39'h0, 7'h2A);
        ev(1'b1, 1'b1, 1'b0, 16'h0006, 39'h12_3456_789A, 7'h11);
        checks++; if (DBL_CNT !== 4'd1 || SGL_CNT !== 4'd1) begin errors++; $display("FAIL ds_cnt got dbl=%0d sgl=%0d want 1 1", DBL_CNT, SGL_CNT); end
        checks++; if (CAP_ADDR !== 16'h0005 || CAP_DBL !== 1'b1 || CAP_SYN !== 7'h2A) begin errors++; $display("FAIL ds_cap got addr=%h dbl=%b syn=%h want 0005 1 2a", CAP_ADDR, CAP_DBL, CAP_SYN); end
        checks++; if (CAP_OVF !== 1'b1) begin errors++; $display("FAIL ds_ovf got %b want 1", CAP_OVF); end
        checks++; if (WB_VLD !== 1'b1 || WB_ADDR !== 16'h0006 || WB_DATA !== 39'h12_3456_789A) begin errors++; $display("FAIL ds_wb got vld=%b addr=%h data=%h want 1 0006 123456789a", WB_VLD, WB_ADDR, WB_DATA); end
        WB_RDY = 1'b1; step(); WB_RDY = 1'b0;
        checks++; if (WB_VLD !== 1'b0) begin errors++; $display("FAIL ds_one_entry got wb_vld=%b want 0", WB_VLD); end
        clr_pulse();
    endtask

    task automatic test_classify();
        // VLD=0 ignored, clean word ignored, ERR-only and SGL+DBL both uncorrectable
        VLD = 1'b0; ERR = 1'b1; SGL = 1'b1; ADDR = 16'h0077; step(); idle_inputs();
        ev(1'b0, 1'b0, 1'b0, 16'h0078, 39'h0, 7'h00);
        checks++; if ({SGL_CNT, DBL_CNT, CAP_VLD, WB_VLD} !== 10'b0) begin errors++; $display("FAIL cls_ignored got %b want 0", {SGL_CNT, DBL_CNT, CAP_VLD, WB_VLD}); end
        ev(1'b1, 1'b0, 1'b0, 16'h0079, 39'h0, 7'h05);
        ev(1'b1, 1'b1, 1'b1, 16'h007A, 39'h0, 7'h06);
        checks++; if (DBL_CNT !== 4'd2 || SGL_CNT !== 4'd0) begin errors++; $display("FAIL cls_cnt got dbl=%0d sgl=%0d want 2 0", DBL_CNT, SGL_CNT); end
        checks++; if (WB_VLD !== 1'b0 || CAP_DBL !== 1'b1 || CAP_ADDR !== 16'h0079) begin errors++; $display("FAIL cls_u_state got wb=%b dbl=%b addr=%h want 0 1 0079", WB_VLD, CAP_DBL, CAP_ADDR); end
        clr_pulse();
    endtask

    task automatic test_queue_full();
        ev(1'b1, 1'b1, 1'b0, 16'h0021, 39'h21, 7'h01);
        ev(1'b1, 1'b1, 1'b0, 16'h0022, 39'h22, 7'h02);
        ev(1'b1, 1'b1, 1'b0, 16'h0023, 39'h23, 7'h03);
        checks++; if (WB_DROP !== 1'b1 || SGL_CNT !== 4'd3) begin errors++; $display("FAIL qf_drop got drop=%b cnt=%0d want 1 3", WB_DROP, SGL_CNT); end
        checks++; if (WB_ADDR !== 16'h0021 || WB_DATA !== 39'h21) begin errors++; $display("FAIL qf_head0 got %h want 0021", WB_ADDR); end
        WB_RDY = 1'b1; step();
        checks++; if (WB_VLD !== 1'b1 || WB_ADDR !== 16'h0022) begin errors++; $display("FAIL qf_head1 got vld=%b addr=%h want 1 0022", WB_VLD, WB_ADDR); end
        step(); WB_RDY = 1'b0;
        checks++; if (WB_VLD !== 1'b0) begin errors++; $display("FAIL qf_empty got %b want 0", WB_VLD); end
        clr_pulse();
        ev(1'b1, 1'b1, 1'b0, 16'h0031, 39'h31, 7'h01);
        ev(1'b1, 1'b1, 1'b0, 16'h0032, 39'h32, 7'h02);
        WB_RDY = 1'b1;
        ev(1'b1, 1'b1, 1'b0, 16'h0033, 39'h33, 7'h03);
        WB_RDY = 1'b0;
        checks++; if (WB_DROP !== 1'b0 || WB_ADDR !== 16'h0032) begin errors++; $display("FAIL qf_popfull got drop=%b head=%h want 0 0032", WB_DROP, WB_ADDR); end
        step();
        checks++; if (WB_VLD !== 1'b1 || WB_ADDR !== 16'h0032 || WB_DATA !== 39'h32) begin errors++; $display("FAIL qf_stable got vld=%b head=%h want 1 0032", WB_VLD, WB_ADDR); end
        WB_RDY = 1'b1; step();
        checks++; if (WB_VLD !== 1'b1 || WB_ADDR !== 16'h0033 || WB_DATA !== 39'h33) begin errors++; $display("FAIL qf_order got vld=%b head=%h want 1 0033", WB_VLD, WB_ADDR); end
        step(); WB_RDY = 1'b0;
        checks++; if (WB_VLD !== 1'b0) begin errors++; $display("FAIL qf_drained got %b want 0", WB_VLD); end
        clr_pulse();
    endtask

    task automatic test_saturation();
        WB_RDY = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ev(1'b1, 1'b1, 1'b0, 16'h0100 + 16'(i), 39'h0, 7'h01);
        end
        checks++; if (SGL_CNT !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d want 15", SGL_CNT); end
        checks++; if (WB_DROP !== 1'b0 || WB_ADDR !== 16'h0110) begin errors++; $display("FAIL sat_stream got drop=%b head=%h want 0 0110", WB_DROP, WB_ADDR); end
        step(); step();
        WB_RDY = 1'b0;
        clr_pulse();
    endtask

    task automatic test_clr_collision();
        ev(1'b1, 1'b0, 1'b1, 16'h0040, 39'h0, 7'h09);
        CLR = 1'b1;
        ev(1'b1, 1'b1, 1'b0, 16'h0044, 39'h44, 7'h04);
        CLR = 1'b0;
        checks++; if (SGL_CNT !== 4'd0 || DBL_CNT !== 4'd0) begin errors++; $display("FAIL clr_cnt got sgl=%0d dbl=%0d want 0 0", SGL_CNT, DBL_CNT); end
        checks++; if (CAP_VLD !== 1'b0 || CAP_OVF !== 1'b0 || IRQ !== 1'b0) begin errors++; $display("FAIL clr_cap got vld=%b ovf=%b irq=%b want 0 0 0", CAP_VLD, CAP_OVF, IRQ); end
        checks++; if (WB_VLD !== 1'b1 || WB_ADDR !== 16'h0044) begin errors++; $display("FAIL clr_push got vld=%b addr=%h want 1 0044", WB_VLD, WB_ADDR); end
    endtask

    task automatic test_mid_reset();
        // Queue still holds 0x0044 from the previous scenario
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (WB_VLD !== 1'b0 || WB_ADDR !== 16'h0000 || IRQ !== 1'b0) begin errors++; $display("FAIL mid_rst got vld=%b addr=%h irq=%b want 0 0000 0", WB_VLD, WB_ADDR, IRQ); end
        VLD = 1'b1; ERR = 1'b1; SGL = 1'b1; ADDR = 16'h0066; OUT = 39'h66; SYN = 7'h06;
        #2 rst_n = 1'b1;
        step();
        idle_inputs();
        checks++; if (SGL_CNT !== 4'd1 || WB_ADDR !== 16'h0066 || CAP_ADDR !== 16'h0066) begin errors++; $display("FAIL mid_rst_first got cnt=%0d wb=%h cap=%h want 1 0066 0066", SGL_CNT, WB_ADDR, CAP_ADDR); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dbl_then_sgl();
        test_classify();
        test_queue_full();
        test_saturation();
        test_clr_collision();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec_err_mon.md
# dec_err_mon

Error monitor and scrub-request stage directly downstream of the 32-bit SEC-DED decoder (39-bit codeword, 7-bit syndrome). It qualifies each decoder result with a valid strobe and counts correctable and uncorrectable events in saturating counters. It captures the first error since the last clear and raises an interrupt. It queues corrected codewords for single-bit errors so the memory controller can write them back (scrub) through a valid/ready handshake.

## Interface

- AW, 16, address width of the word being decoded
- CW, 16, width of each error counter
- QD, 2, scrub queue depth in entries (power of two, >= 2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- VLD  in  1  decoder outputs and ADDR are valid this cycle
- ADDR  in  AW  address of the decoded word
- OUT  in  39  corrected codeword from decoder
- SYN  in  7  syndrome from decoder
- ERR  in  1  decoder error flag
- SGL  in  1  decoder single-bit (corrected) flag
- DBL  in  1  decoder double-bit (uncorrectable) flag
- CLR  in  1  one-cycle pulse: clear counters, capture and sticky flags
- IRQ_EN  in  1  interrupt enable
- SGL_CNT  out  CW  single-error count, saturating
- DBL_CNT  out  CW  uncorrectable-error count, saturating
- CAP_VLD  out  1  capture registers hold an error
- CAP_DBL  out  1  captured error was uncorrectable
- CAP_ADDR  out  AW  captured address
- CAP_SYN  out  7  captured syndrome
- CAP_OVF  out  1  sticky: an error arrived while CAP_VLD was set
- WB_DROP  out  1  sticky: a scrub request was lost because the queue was full
- IRQ  out  1  interrupt, level
- WB_VLD  out  1  scrub request valid
- WB_ADDR  out  AW  scrub address
- WB_DATA  out  39  corrected codeword to write back
- WB_RDY  in  1  consumer accepts the scrub request

## Operation

- **Classification.** Inputs are ignored when VLD=0. With VLD=1:
  - uncorrectable event (u) = DBL | (ERR & ~SGL)
  - single event (s) = SGL & ~DBL
  - SGL=DBL=1 is classified as u only.
  - ERR=0 with SGL=DBL=0 is a clean word: no effect.
- **Counters.** SGL_CNT increments by 1 on s and DBL_CNT on u. Each saturates at 2^CW-1 and never wraps.
- **Capture.** On s or u with CAP_VLD=0, load CAP_ADDR=ADDR, CAP_SYN=SYN, CAP_DBL=u, and set CAP_VLD. With CAP_VLD=1, the capture registers are unchanged and CAP_OVF is set.
- **Scrub queue.** A FIFO of QD entries holding {ADDR, OUT}.
  - Push on s only; u events are never queued.
  - Pop when WB_VLD & WB_RDY.
  - A push while full with no pop in the same cycle is discarded and sets WB_DROP.
  - A push while full with a pop in the same cycle is accepted.
  - WB_VLD = queue not empty. WB_ADDR/WB_DATA show the head entry and stay stable while WB_VLD=1 and WB_RDY=0.
  - Pointers wrap modulo QD.
- **IRQ.** IRQ = IRQ_EN & (CAP_VLD | WB_DROP). It is combinational from registered state.
- **CLR.**
  - Zeroes SGL_CNT, DBL_CNT, CAP_*, CAP_OVF and WB_DROP.
  - An event in the same cycle as CLR is dropped for counters and capture.
  - The scrub queue is not flushed by CLR, and a same-cycle s is still pushed. Corrected data must still be written back.

## Timing

- Reset (rst_n=0, asynchronous): all counters 0, CAP_VLD/CAP_DBL/CAP_OVF/WB_DROP 0, CAP_ADDR/CAP_SYN 0, queue empty, WB_VLD 0, IRQ 0, WB_ADDR/WB_DATA 0.
- Reset deassertion mid-stream: the first VLD sampled is on the first rising edge with rst_n=1.
- Latency:
  - Event at edge N: counters, capture and sticky flags are visible after edge N.
  - WB_VLD rises after edge N when the queue was empty; there is no combinational bypass.
- Handshake:
  - The monitor never drops WB_VLD without a pop.
  - WB_RDY may be asserted before WB_VLD.
  - One pop per cycle maximum.
- Throughput: one decoder result per cycle sustained. The scrub queue drains at most one entry per cycle.

## Test plan

- **Reset values.** Assert rst_n=0 mid-run with a non-empty queue -> all outputs 0 immediately (asynchronous), WB_VLD=0.
- **Single error.** VLD with SGL=1, ERR=1, ADDR=0x0012, SYN=7'b0000011, OUT=39'h0000000000 -> next cycle SGL_CNT=1, CAP_VLD=1, CAP_DBL=0, CAP_SYN=0000011, WB_VLD=1 with WB_ADDR=0x0012. With IRQ_EN=1, IRQ=1.
- **Double then single.** DBL at ADDR=0x0005, then SGL at 0x0006 -> DBL_CNT=1, SGL_CNT=1, CAP_ADDR=0x0005, CAP_DBL=1, CAP_OVF=1. Exactly one queue entry, addr 0x0006.
- **Queue full.** WB_RDY=0, three consecutive SGL events (QD=2) -> WB_DROP=1, queue holds the first two addresses. Repeat with WB_RDY=1 on the third cycle -> no drop, and entries drain in order.
- **Saturation.** CW=4, 17 SGL events -> SGL_CNT holds 15.
- **CLR collision.** CLR pulse coincident with a SGL event -> counters 0, CAP_VLD=0, but the entry is still pushed and WB_VLD=1 next cycle.
